// File: rtl/chacha_pkg.sv
// chacha_pkg: shared constants, state encoding and quarter-round index tables
// for the ChaCha block engine.
package chacha_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WORD_AW = 4;   // 16 state words
  localparam int unsigned BYTE_AW = 6;   // 64 state bytes
  localparam int unsigned CTR_W   = 7;   // up to 4*30 quarter-rounds

  localparam logic [WORD_W-1:0] SIGMA0 = 32'h6170_7865;
  localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320_646e;
  localparam logic [WORD_W-1:0] SIGMA2 = 32'h7962_2d32;
  localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b20_6574;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINAL
  } state_e;

  typedef logic [WORD_AW-1:0] widx_t;

  // Nibble {qr,pos} holds the state word fed to operand pos (a,b,c,d) of
  // quarter-round qr within a column or diagonal round.
  localparam logic [63:0] QR_COL_TBL  = 64'hfb73_ea62_d951_c840;
  localparam logic [63:0] QR_DIAG_TBL = 64'he943_d872_cb61_fa50;

  function automatic widx_t qr_word(input logic diag, input logic [1:0] qr,
                                    input logic [1:0] pos);
    logic [63:0] tbl;
    tbl = diag ? QR_DIAG_TBL : QR_COL_TBL;
    return tbl[{qr, pos, 2'b00} +: 4];
  endfunction

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// chacha_quarter_round: purely combinational ChaCha quarter-round on a,b,c,d.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] b_in,
  input  logic [WORD_W-1:0] c_in,
  input  logic [WORD_W-1:0] d_in,
  output logic [WORD_W-1:0] a_out,
  output logic [WORD_W-1:0] b_out,
  output logic [WORD_W-1:0] c_out,
  output logic [WORD_W-1:0] d_out
);

  // Add/xor/rotate chain with rotations 16, 12, 8, 7.
  always_comb begin
    logic [WORD_W-1:0] a, b, c, d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b;  d = rotl(d ^ a, 16);
    c = c + d;  b = rotl(b ^ c, 12);
    a = a + b;  d = rotl(d ^ a, 8);
    c = c + d;  b = rotl(b ^ c, 7);
    a_out = a;
    b_out = b;
    c_out = c;
    d_out = d;
  end

endmodule

// File: rtl/chacha_block_core.sv
// chacha_block_core: ChaCha block function, one quarter-round per cycle,
// ROUNDS rounds then a single feed-forward cycle. Byte-wide load/readback.
// Optional macro CHACHA_CTR_INC_EN: word 12 of the input copy increments at
// the end of each block and back-to-back starts produce consecutive blocks.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BYTE_AW-1:0] addr_in,
  input  logic [7:0]         data_in,
  input  logic               write,
  input  logic               start,
  output logic [7:0]         data_out,
  output logic               ready,
  output logic               done
);

  localparam logic [CTR_W-1:0] LAST_QR = CTR_W'(4 * ROUNDS - 1);

  state_e                        state_q, state_d;
  logic [CTR_W-1:0]              ctr_q, ctr_d;
  logic [15:0][WORD_W-1:0]       work_q, work_d;
  logic [15:0][WORD_W-1:0]       in_q, in_d;
  logic                          done_q, done_d;
`ifdef CHACHA_CTR_INC_EN
  logic                          restore_q, restore_d;
`endif

  logic [3:0][WORD_AW-1:0]       qr_idx;
  logic [WORD_W-1:0]             qa_in, qb_in, qc_in, qd_in;
  logic [WORD_W-1:0]             qa_out, qb_out, qc_out, qd_out;

  // Select the four words of the current quarter-round: ctr[1:0] picks the
  // QR, ctr[2] (LSB of the round number) picks column vs diagonal.
  always_comb begin
    for (int unsigned p = 0; p < 4; p++) begin
      qr_idx[p] = qr_word(ctr_q[2], ctr_q[1:0], 2'(p));
    end
    qa_in = work_q[qr_idx[0]];
    qb_in = work_q[qr_idx[1]];
    qc_in = work_q[qr_idx[2]];
    qd_in = work_q[qr_idx[3]];
  end

  chacha_quarter_round u_qr (
    .a_in  (qa_in),
    .b_in  (qb_in),
    .c_in  (qc_in),
    .d_in  (qd_in),
    .a_out (qa_out),
    .b_out (qb_out),
    .c_out (qc_out),
    .d_out (qd_out)
  );

  // Next-state: host load/start in IDLE, quarter-rounds in RUN, feed-forward in FINAL.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    work_d  = work_q;
    in_d    = in_q;
    done_d  = 1'b0;
`ifdef CHACHA_CTR_INC_EN
    restore_d = restore_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef CHACHA_CTR_INC_EN
          // An unmodified previous result is replaced by the already
          // incremented input copy, so the next block is the successor.
          if (restore_q) begin
            work_d = in_q;
          end else begin
            in_d = work_q;
          end
          restore_d = 1'b0;
`else
          in_d = work_q;
`endif
          ctr_d   = '0;
          state_d = ST_RUN;
        end else if (write) begin
          work_d[addr_in[5:2]][{addr_in[1:0], 3'b000} +: 8] = data_in;
`ifdef CHACHA_CTR_INC_EN
          restore_d = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        work_d[qr_idx[0]] = qa_out;
        work_d[qr_idx[1]] = qb_out;
        work_d[qr_idx[2]] = qc_out;
        work_d[qr_idx[3]] = qd_out;
        ctr_d = ctr_q + CTR_W'(1);
        if (ctr_q == LAST_QR) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        for (int unsigned w = 0; w < 16; w++) begin
          work_d[w] = work_q[w] + in_q[w];
        end
`ifdef CHACHA_CTR_INC_EN
        in_d[12]  = in_q[12] + 32'd1;
        restore_d = 1'b1;
`endif
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      work_q  <= '0;
      in_q    <= '0;
      done_q  <= 1'b0;
`ifdef CHACHA_CTR_INC_EN
      restore_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      work_q  <= work_d;
      in_q    <= in_d;
      done_q  <= done_d;
`ifdef CHACHA_CTR_INC_EN
      restore_q <= restore_d;
`endif
    end
  end

  assign data_out = work_q[addr_in[5:2]][{addr_in[1:0], 3'b000} +: 8];
  assign ready    = (state_q == ST_IDLE);
  assign done     = done_q;

endmodule

// File: doc/chacha_block_core.md
Name: chacha_block_core

Overview:
- Parametrised ChaCha block-function engine; successor to the fixed 20-round byte-loaded block.
- Round count is a parameter (ChaCha8/12/20).
- Adds the RFC 8439 feed-forward (working state + input state), a start/done handshake and protected loading.
- Sits between the byte-wide host register interface and the keystream consumer; one 64-byte block per start.

Parameters:
- ROUNDS, 20, total rounds; even, 2..30. Column/diagonal rounds alternate, starting with column.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr_in  in  6  byte address; [5:2] = state word 0..15, [1:0] = byte lane, little-endian
- data_in  in  8  write byte
- write  in  1  byte write strobe, honoured only in IDLE
- start  in  1  start strobe, honoured only in IDLE
- data_out  out  8  byte of working state at addr_in, combinational
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse when a block completes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All 16 working words and 16 input-copy words cleared to 0.
  - FSM goes to IDLE; round counter cleared.
  - ready=1, done=0.
- States:
  - IDLE: write sets working byte addr_in to data_in.
  - IDLE, start=1 (takes priority over write in the same cycle; that write is dropped): copy the working state to the input copy, clear the counter, go to RUN, ready=0.
  - RUN: one quarter-round per cycle, 4*ROUNDS cycles.
    - Counter [1:0] selects the QR within the round.
    - Counter LSB of the round number selects column (0) or diagonal (1).
    - Column QRs: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
    - Diagonal QRs: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
  - RUN exit: after the last QR go to FINAL.
  - FINAL: one cycle. Each word = working + input copy, mod 2^32. Then go to IDLE with done=1 for exactly one cycle and ready=1.
- Latency: start sampled at edge E0; ready=0 from E0; QRs at E1..E(4*ROUNDS); feed-forward at E(4*ROUNDS+1); ready=1 and done=1 after that edge. ROUNDS=20 gives 81 cycles.
- Arithmetic: all 32-bit, wrap-around. Rotations 16, 12, 8, 7 left.
- write or start during RUN/FINAL: ignored, no state change, no queueing.
- data_out:
  - Always reflects the working state.
  - Holds intermediate values during RUN; valid only when ready=1.
  - After done it holds the keystream until the next write/start.
- A new start is permitted on the cycle after done. The result block becomes the next input unless reloaded by the host.
- Reset asserted mid-RUN: immediate return to IDLE with cleared state; done not pulsed.

Optional Feature:
- Macro CHACHA_CTR_INC_EN.
- Defined:
  - On start, the input copy takes the pre-start working state as now.
  - At FINAL, word 12 of the input copy is incremented (wrap 0xFFFFFFFF->0).
  - The working state is restored from the incremented input copy after done only if the host issues the next start with no intervening write.
  - Restore happens on the start edge: working := input copy, then RUN.
  - Successive starts therefore produce consecutive blocks.
- Undefined: no increment; start always uses the current working state as the input.

Decomposition:
- Package chacha_pkg:
  - sigma constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574
  - FSM state typedef (IDLE/RUN/FINAL)
  - QR index tables
  - word/byte address widths
- Sub-module chacha_quarter_round: pure combinational full quarter-round on a,b,c,d (32-bit each). The core instantiates one, muxes words in and out by QR index, and holds no state in it.

Test Plan:
- Reset then read all 64 addresses -> data_out=0x00, ready=1, done=0.
- RFC 8439 §2.3.2 vector:
  - Stimulus: sigma, key 00..1f, counter 1, nonce 00000009 0000004a 00000000 loaded bytewise; start.
  - Response: done exactly 81 cycles after start; bytes 0..3 read 10 f1 e7 e4; word 15 = 0x4e3c50a2.
- ROUNDS=8, all-zero input:
  - Response: done after 33 cycles; all 64 bytes match the reference model's ChaCha8 keystream.
- Protection during RUN:
  - Stimulus: write=1 at addr 0 with 0xFF, then start=1 pulsed again.
  - Response: final output unchanged vs the clean run; no second done; ready stays 0 until the first completion.
- Reset mid-RUN:
  - Stimulus: rst_n low at cycle 40 after start.
  - Response: ready=1 immediately, all bytes 0, no done pulse; a subsequent load+start produces the correct result.
- CHACHA_CTR_INC_EN:
  - Stimulus: two back-to-back starts without writes.
  - Response: second block equals the RFC vector with counter 2. With counter 0xFFFFFFFF, the next block uses counter 0.
